// File: rtl/hazard_stall_controller.sv
// ============================================================================
// hazard_stall_controller
//   Front-end pipeline sequencing: load-use stall, fixed-latency mul/div hold
//   and taken-branch squash. Optional stall counter under STALL_COUNTER_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_stall_controller #(
  parameter int MULDIV_CYCLES = 8,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       id_muldiv,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       branch_taken,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       if_id_flush,
  output logic       id_ex_bubble,
  output logic       busy
`ifdef STALL_COUNTER_EN
  ,
  output logic [CNT_W-1:0] stall_count
`endif
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [7:0] CNT_LOAD = 8'(MULDIV_CYCLES - 1);

  generate
    if (MULDIV_CYCLES < 1 || MULDIV_CYCLES > 255 || CNT_W < 1) begin : g_param_check
      $error("hazard_stall_controller: parameter out of range");
    end
  endgenerate

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next;
  logic       load_use;

  // Register 0 is hardwired zero, so a load targeting it is never a hazard.
  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 8'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    busy         = 1'b0;

    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (id_muldiv) begin
            state_next = BUSY;
            cnt_next   = CNT_LOAD;
          end
        end
        BUSY: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          busy         = 1'b1;
          // The cnt==0 cycle is still a stall; RUN resumes on the next one.
          if (cnt == 8'd0) begin
            state_next = RUN;
          end else begin
            cnt_next = cnt - 8'd1;
          end
        end
        default: begin
          state_next = RUN;
          cnt_next   = 8'd0;
        end
      endcase
    end
  end

`ifdef STALL_COUNTER_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (!pc_write && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
// ============================================================================
// tb_hazard_stall_controller
//   Table-driven plus hand-sequenced checks with a queue-based scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hazard_stall_controller;

  localparam int MULDIV_CYCLES = 4;
  localparam int CNT_W         = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, id_muldiv, ex_mem_read, branch_taken;
  logic       pc_write, if_id_write, if_id_flush, id_ex_bubble, busy;
`ifdef STALL_COUNTER_EN
  logic [CNT_W-1:0] stall_count;
`endif

  hazard_stall_controller #(
    .MULDIV_CYCLES(MULDIV_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .id_muldiv   (id_muldiv),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .branch_taken(branch_taken),
    .pc_write    (pc_write),
    .if_id_write (if_id_write),
    .if_id_flush (if_id_flush),
    .id_ex_bubble(id_ex_bubble),
    .busy        (busy)
`ifdef STALL_COUNTER_EN
    ,
    .stall_count (stall_count)
`endif
  );

  always #5 clk = ~clk;

  // expected outputs packed as {pc_write, if_id_write, if_id_flush, id_ex_bubble, busy}
  localparam logic [4:0] E_RUN   = 5'b11000;
  localparam logic [4:0] E_LU    = 5'b00010;
  localparam logic [4:0] E_BR    = 5'b11110;
  localparam logic [4:0] E_BUSY  = 5'b00011;
  localparam logic [4:0] E_RESET = 5'b00010;

  typedef struct {
    string      name;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       muldiv;
    logic       mem_read;
    logic [4:0] ert;
    logic       br;
    logic [4:0] exp;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int exp_sc = 0;

  logic [4:0] sb_exp[$];
  string      sb_name[$];

  task automatic step(input string name, input logic r,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic uses, input logic md, input logic mr,
                      input logic [4:0] ert, input logic br,
                      input logic [4:0] exp);
    logic [4:0] e;
    logic [4:0] act;
    string      n;
    rst = r; id_rs = rs; id_rt = rt; id_uses_rt = uses; id_muldiv = md;
    ex_mem_read = mr; ex_rt = ert; branch_taken = br;
    if (r) exp_sc = 0;
    sb_exp.push_back(exp);
    sb_name.push_back(name);
    @(negedge clk);
    e   = sb_exp.pop_front();
    n   = sb_name.pop_front();
    act = {pc_write, if_id_write, if_id_flush, id_ex_bubble, busy};
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s: outputs {pc,ifid,flush,bubble,busy} got %b want %b", n, act, e);
    end
`ifdef STALL_COUNTER_EN
    total++;
    if (stall_count !== CNT_W'(exp_sc)) begin
      bad++;
      $display("FAIL %s stall_count: got %0d want %0d", n, stall_count, exp_sc);
    end
`endif
    if (!r && !e[4] && exp_sc < (2**CNT_W - 1)) exp_sc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string name, input logic [4:0] exp);
    step(name, 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, exp);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{"no_hazard",    5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0, E_RUN};
    vecs[1] = '{"lu_rs",        5'd5, 5'd2, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, E_LU};
    vecs[2] = '{"lu_r0",        5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, E_RUN};
    vecs[3] = '{"rt_unused",    5'd3, 5'd5, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, E_RUN};
    vecs[4] = '{"lu_rt",        5'd3, 5'd5, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, E_LU};
    vecs[5] = '{"load_nomatch", 5'd3, 5'd4, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, E_RUN};
    vecs[6] = '{"no_load",      5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 5'd7, 1'b0, E_RUN};
    vecs[7] = '{"branch",       5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, E_BR};
    vecs[8] = '{"branch_lu",    5'd6, 5'd2, 1'b0, 1'b0, 1'b1, 5'd6, 1'b1, E_BR};
    vecs[9] = '{"lu_rs31",      5'd31, 5'd0, 1'b0, 1'b0, 1'b1, 5'd31, 1'b0, E_LU};

    rst = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_muldiv = 1'b0;
    ex_mem_read = 1'b0; ex_rt = '0; branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    step("reset", 1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, E_RESET);
    idle("after_reset", E_RUN);

    // Mul/div hold: issue, MULDIV_CYCLES busy cycles, then RUN.
    step("md_issue", 1'b0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, E_RUN);
    for (int i = 0; i < MULDIV_CYCLES; i++) idle("md_busy", E_BUSY);
    idle("md_done", E_RUN);

    foreach (vecs[i])
      step(vecs[i].name, 1'b0, vecs[i].rs, vecs[i].rt, vecs[i].uses_rt, vecs[i].muldiv,
           vecs[i].mem_read, vecs[i].ert, vecs[i].br, vecs[i].exp);

    // Branch beats load-use and mul/div; no BUSY afterwards.
    step("br_prio", 1'b0, 5'd5, 5'd2, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, E_BR);
    idle("br_prio_nobusy", E_RUN);

    // Load-use first, then the mul/div issues.
    step("lu_md_stall", 1'b0, 5'd5, 5'd2, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, E_LU);
    step("lu_md_issue", 1'b0, 5'd5, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, E_RUN);
    for (int i = 0; i < MULDIV_CYCLES; i++) idle("lu_md_busy", E_BUSY);
    idle("lu_md_done", E_RUN);

    // Back-to-back mul/div: second one waits in ID, issues in the first RUN cycle.
    step("b2b_issue1", 1'b0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, E_RUN);
    for (int i = 0; i < MULDIV_CYCLES; i++)
      step("b2b_busy1", 1'b0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0, E_BUSY);
    step("b2b_issue2", 1'b0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, E_RUN);
    for (int i = 0; i < MULDIV_CYCLES; i++) idle("b2b_busy2", E_BUSY);
    idle("b2b_done", E_RUN);

    // Branch ignored mid-BUSY; reset on the 2nd BUSY cycle aborts the hold.
    step("mid_issue", 1'b0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, E_RUN);
    step("mid_busy_br", 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, E_BUSY);
    step("mid_rst", 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, E_RESET);
    idle("mid_rst_release", E_RUN);
    idle("mid_rst_run", E_RUN);

    // Long stall run to exercise counter saturation.
    for (int i = 0; i < 10; i++)
      step("sat_lu", 1'b0, 5'd8, 5'd2, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, E_LU);
    idle("sat_run", E_RUN);
`ifdef STALL_COUNTER_EN
    @(negedge clk);
    total++;
    if (stall_count !== 3'd7) begin
      bad++;
      $display("FAIL sat_hold: stall_count got %0d want 7", stall_count);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Sequences the front-end pipeline registers for the 5-stage core: generates the PC write enable, the IF/ID write enable and flush, and the ID/EX bubble select. It combines three conditions: load-use hazard detection, a fixed-latency multicycle multiply/divide hold, and taken-branch squash. A small registered FSM with a down-counter times the multicycle hold; hazard and branch decisions are Mealy outputs, effective in the cycle they are detected.

## Interface
- MULDIV_CYCLES, 8: stall cycles inserted after a mul/div issues; legal range 1..255.
- CNT_W, 16: width of the stall counter (only used with STALL_COUNTER_EN).
- clk  input  1  pipeline clock, all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- id_rs  input  5  rs field of the instruction in ID.
- id_rt  input  5  rt field of the instruction in ID.
- id_uses_rt  input  1  ID instruction reads rt as a source.
- id_muldiv  input  1  ID instruction is a multicycle mul/div.
- ex_mem_read  input  1  instruction in EX is a load.
- ex_rt  input  5  destination rt of the instruction in EX.
- branch_taken  input  1  branch in EX resolved taken (redirect this cycle).
- pc_write  output  1  PC register write enable.
- if_id_write  output  1  IF/ID register write enable.
- if_id_flush  output  1  IF/ID loads a NOP on the next edge.
- id_ex_bubble  output  1  ID/EX control fields forced to zero.
- busy  output  1  FSM in BUSY (mul/div hold active).
- stall_count  output  CNT_W  stall cycle counter (STALL_COUNTER_EN only).

## Operation
- FSM states: RUN, BUSY. Down-counter cnt, width 8.
- load_use = ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt)).
- RUN, priority high to low:
  - branch_taken: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1; stay RUN. A mul/div in ID is squashed and never enters BUSY.
  - load_use: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=1; stay RUN. The hazard clears on its own the next cycle, so the stall is exactly 1 cycle.
  - id_muldiv: the instruction issues normally (pc_write=1, if_id_write=1, id_ex_bubble=0). Next state BUSY, cnt <= MULDIV_CYCLES-1.
  - otherwise: pc_write=1, if_id_write=1, flush=0, bubble=0.
- BUSY: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=1, busy=1.
  - cnt decrements each cycle.
  - When cnt==0 the cycle is still stalled, and the next state is RUN.
  - branch_taken, load_use and id_muldiv are ignored in BUSY.
- Reset (asserted): state=RUN, cnt=0, pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=1, busy=0, stall_count=0. Reset mid-BUSY aborts the hold immediately.
- Register 0 never causes a load-use stall.

## Timing
- load_use, branch and RUN outputs are combinational from inputs in the same cycle. There are no registered output delays.
- Mul/div issued at edge N: BUSY during cycles N+1 .. N+MULDIV_CYCLES. RUN resumes at cycle N+MULDIV_CYCLES+1, when the next instruction advances.
- A mul/div in ID with a load_use also present: the load-use stall is taken first (1 cycle), and the mul/div issues on the following cycle.
- Back-to-back mul/div: the second instruction sits in ID during BUSY and issues in the first RUN cycle, re-entering BUSY.
- MULDIV_CYCLES=1: exactly one BUSY cycle.

## Configuration
- STALL_COUNTER_EN defined:
  - stall_count port is present.
  - It increments once per cycle in which pc_write==0 and rst is low.
  - It saturates at 2^CNT_W-1 and clears only on reset.
- STALL_COUNTER_EN undefined: the stall_count port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset: with rst high, outputs are pc_write=0, if_id_write=0, bubble=1, flush=0, busy=0. After release with no hazards, pc_write=1, if_id_write=1, bubble=0.
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 -> one cycle of pc_write=0, if_id_write=0, bubble=1. With ex_rt=0, or id_rt=5 and id_uses_rt=0 -> no stall.
- Mul/div with MULDIV_CYCLES=4: id_muldiv=1 for one edge -> busy=1 for exactly 4 cycles with pc_write=0, then RUN. stall_count=4 when STALL_COUNTER_EN is defined.
- Branch priority: branch_taken=1 together with load_use and id_muldiv -> flush=1, bubble=1, pc_write=1; busy stays 0.
- Mid-BUSY: branch_taken=1 is ignored (flush=0). Asserting rst on the 2nd BUSY cycle -> busy=0 immediately; after release, normal RUN.
- Counter saturation with CNT_W=3 and STALL_COUNTER_EN defined: 10 stall cycles -> stall_count holds at 7.
